// File: rtl/led_pattern_gen_pkg.sv
// led_pattern_gen_pkg: mode encodings and width helper shared by the LED pattern generator
package led_pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_SCAN = 2'b10,
        MODE_GRAY = 2'b11
    } mode_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/led_pattern_gen_tick_gen.sv
// tick_gen: prescaler producing a one-cycle step enable every DIV enabled cycles
module tick_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int PW = clog2(DIV) < 1 ? 1 : clog2(DIV);

    logic [PW-1:0] presc;

    assign step = en && (presc == PW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || step)
            presc <= '0;
        else if (en)
            presc <= presc + PW'(1);
    end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern generator (up, down, bouncing scan, gray count)
module led_pattern_gen
    import led_pattern_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] led,
    output logic             tick
);

    localparam int PW = clog2(WIDTH);

    logic             step;
    logic [WIDTH-1:0] cnt, cnt_nx, cnt_inc, led_nx;
    logic [PW-1:0]    pos, pos_nx, scan_pos;
    logic             dir, dir_nx, scan_dir;

    tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .step (step)
    );

    // Scan bounces between the end bits without dwelling on them.
    always_comb begin
        cnt_inc  = cnt + WIDTH'(1);
        scan_pos = pos;
        scan_dir = dir;
        if (!dir) begin
            scan_pos = (pos == PW'(WIDTH - 1)) ? PW'(WIDTH - 2) : pos + PW'(1);
            scan_dir = (pos == PW'(WIDTH - 1));
        end else begin
            scan_pos = (pos == '0) ? PW'(1) : pos - PW'(1);
            scan_dir = (pos != '0);
        end
    end

    always_comb begin
        cnt_nx = cnt;
        pos_nx = pos;
        dir_nx = dir;
        led_nx = led;
        if (load) begin
            cnt_nx = load_val;
            pos_nx = '0;
            dir_nx = 1'b0;
            case (mode_t'(mode))
                MODE_SCAN: led_nx = WIDTH'(1);
                MODE_GRAY: led_nx = load_val ^ (load_val >> 1);
                default:   led_nx = load_val;
            endcase
        end else if (step) begin
            case (mode_t'(mode))
                MODE_UP: begin
                    cnt_nx = cnt_inc;
                    led_nx = cnt_inc;
                end
                MODE_DOWN: begin
                    cnt_nx = cnt - WIDTH'(1);
                    led_nx = cnt - WIDTH'(1);
                end
                MODE_GRAY: begin
                    cnt_nx = cnt_inc;
                    led_nx = cnt_inc ^ (cnt_inc >> 1);
                end
                MODE_SCAN: begin
                    pos_nx = scan_pos;
                    dir_nx = scan_dir;
                    led_nx = WIDTH'(1) << scan_pos;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            pos  <= '0;
            dir  <= 1'b0;
            led  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nx;
            pos  <= pos_nx;
            dir  <= dir_nx;
            led  <= led_nx;
            tick <= step && !load;
        end
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8, number of LED outputs / pattern bits (legal 2..32).
REQ-002 Parameter DIV, default 50000000, clk cycles per pattern step (legal >= 1).
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 en  in  1  step enable; low freezes prescaler and pattern.
REQ-006 mode  in  2  pattern select: 00 UP, 01 DOWN, 10 SCAN, 11 GRAY.
REQ-007 load  in  1  synchronous load strobe.
REQ-008 load_val  in  WIDTH  value loaded into pattern count.
REQ-009 led  out  WIDTH  registered pattern output.
REQ-010 tick  out  1  registered one-cycle pulse, high in the cycle a stepped led value first appears.

Function
REQ-011 Prescaler SHALL count 0..DIV-1 while en=1, hold while en=0; step = en AND prescaler==DIV-1; on step prescaler wraps to 0.
REQ-012 DIV=1 SHALL yield step every cycle en=1.
REQ-013 No derived clock SHALL be generated; step is a clock enable only.
REQ-014 State: cnt[WIDTH-1:0], pos (0..WIDTH-1), dir (0=toward MSB, 1=toward LSB).
REQ-015 On step, mode UP: cnt <= cnt+1 mod 2^WIDTH; led <= new cnt.
REQ-016 On step, mode DOWN: cnt <= cnt-1 mod 2^WIDTH (0 wraps to all-ones); led <= new cnt.
REQ-017 On step, mode GRAY: cnt <= cnt+1 mod 2^WIDTH; led <= new_cnt XOR (new_cnt >> 1).
REQ-018 On step, mode SCAN: dir=0 and pos<WIDTH-1 -> pos+1; pos==WIDTH-1 -> pos<=WIDTH-2, dir<=1; dir=1 and pos>0 -> pos-1; pos==0 -> pos<=1, dir<=0; led <= one-hot(new pos); cnt unchanged.
REQ-019 Non-SCAN modes SHALL leave pos/dir unchanged; SCAN leaves cnt unchanged; mode sampled only at step or load, mode change between steps does not alter led.
REQ-020 tick SHALL be 1 exactly in the cycle after a step edge, else 0.
REQ-021 Load (load=1) SHALL take priority over step, independent of en: cnt<=load_val, pos<=0, dir<=0, prescaler<=0, led<=mode mapping of loaded state (UP/DOWN: load_val; GRAY: gray(load_val); SCAN: one-hot bit 0); tick SHALL stay 0 that cycle.
REQ-022 Latency: step edge to led change 1 cycle (led registered at the same edge as state).

Reset
REQ-023 rst=1 at an edge SHALL force prescaler=0, cnt=0, pos=0, dir=0, led=0, tick=0, overriding load and step.
REQ-024 Reset mid-interval SHALL discard partial prescale; first step occurs DIV cycles after first en=1 cycle post-reset.

Structure
REQ-025 Shared package SHALL hold mode encodings (MODE_UP, MODE_DOWN, MODE_SCAN, MODE_GRAY) and a clog2 function for prescaler width.
REQ-026 Prescaler SHALL be sub-module tick_gen (params DIV; ports clk, rst, en, clr, step); pattern logic in led_pattern_gen.

Verification (WIDTH=8, DIV=4 unless stated)
REQ-027 rst, then en=1 mode=UP -> tick in cycles 5, 9, 13 after release; led 0x01, 0x02, 0x03.
REQ-028 rst, mode=DOWN, en=1 -> first led 0xFF, second 0xFE.
REQ-029 WIDTH=4, DIV=1, mode=SCAN, en=1 -> led 0010,0100,1000,0100,0010,0001,0010.
REQ-030 mode=GRAY from reset -> led 0x01, 0x03, 0x02, 0x06.
REQ-031 en dropped 2 cycles after step for 10 cycles -> no tick; resuming, next step 2 cycles after en=1; load=1 load_val=0xA5 mode=UP coincident with step -> led=0xA5, tick=0, next step 4 cycles later gives 0xA6.
REQ-032 rst asserted same edge as load and step -> led=0x00, tick=0, prescaler restarts from 0.
